// File: rtl/vga_timing_480.sv
// 640x480@60 VGA raster generator: free-running h/v counters plus one registered
// decode stage that drives sync, active-video, coordinates and line/frame strobes.
module vga_timing_480 #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] h_cnt_p0;
  logic [CNT_W-1:0] v_cnt_p0;
  logic             h_last_p0;
  logic             v_last_p0;
  logic             hsync_p0;
  logic             vsync_p0;
  logic             video_on_p0;
  logic [CNT_W-1:0] x_p0;
  logic [CNT_W-1:0] y_p0;
  logic             line_start_p0;
  logic             frame_start_p0;

  // Stage p0: raster counters
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (enable) begin
      if (h_last_p0) begin
        h_cnt_p0 <= '0;
        v_cnt_p0 <= v_last_p0 ? '0 : v_cnt_p0 + ONE;
      end else begin
        h_cnt_p0 <= h_cnt_p0 + ONE;
      end
    end
  end

  always_comb begin
    h_last_p0      = (h_cnt_p0 == H_MAX);
    v_last_p0      = (v_cnt_p0 == V_MAX);
    hsync_p0       = ((h_cnt_p0 >= HS_FIRST) && (h_cnt_p0 <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_p0       = ((v_cnt_p0 >= VS_FIRST) && (v_cnt_p0 <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    video_on_p0    = (h_cnt_p0 < H_VIS) && (v_cnt_p0 < V_VIS);
    x_p0           = video_on_p0 ? h_cnt_p0 : '0;
    y_p0           = video_on_p0 ? v_cnt_p0 : '0;
    line_start_p0  = (h_cnt_p0 == '0);
    frame_start_p0 = (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
  end

  // Stage p1: registered outputs, one cycle behind the counters; held while stalled
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      hsync       <= hsync_p0;
      vsync       <= vsync_p0;
      video_on    <= video_on_p0;
      x           <= x_p0;
      y           <= y_p0;
      line_start  <= line_start_p0;
      frame_start <= frame_start_p0;
    end
  end

endmodule

// File: tb/tb_vga_timing_480.sv
// Scoreboard bench for vga_timing_480: default horizontal timing, shortened vertical
// geometry (8 visible + 2 FP + 2 sync + 3 BP = 15 lines, 12000-cycle frame).
module tb_vga_timing_480;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } obs_t;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       enable;
  logic       hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] x, y;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    fails  = 0;
  int    n      = 0;
  obs_t  cur;

  vga_timing_480 #(
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .enable     (enable),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  always #5 clk_in = ~clk_in;

  function automatic obs_t mk(input logic hs, input logic vs, input logic von,
                              input int xv, input int yv, input logic ls, input logic fs);
    obs_t o;
    o.hs = hs; o.vs = vs; o.von = von;
    o.x = 10'(xv); o.y = 10'(yv);
    o.ls = ls; o.fs = fs;
    return o;
  endfunction

  // Expected output after the n-th enabled edge since reset release
  function automatic obs_t model(input int nn);
    int   p, h, v;
    logic von;
    p   = nn - 1;
    h   = p % 800;
    v   = (p / 800) % 15;
    von = (h < 640) && (v < 8);
    return mk(!((h >= 656) && (h <= 751)), !((v >= 10) && (v <= 11)), von,
              von ? h : 0, von ? v : 0, h == 0, (h == 0) && (v == 0));
  endfunction

  function automatic bit directed(input int nn, output obs_t e, output string nm);
    bit hit = 1'b1;
    e  = mk(1, 1, 0, 0, 0, 0, 0);
    nm = "";
    case (nn)
      1:     begin e = mk(1, 1, 1,   0, 0, 1, 1); nm = "edge1";      end
      2:     begin e = mk(1, 1, 1,   1, 0, 0, 0); nm = "edge2";      end
      640:   begin e = mk(1, 1, 1, 639, 0, 0, 0); nm = "last_px";    end
      641:   begin e = mk(1, 1, 0,   0, 0, 0, 0); nm = "h_blank";    end
      657:   begin e = mk(0, 1, 0,   0, 0, 0, 0); nm = "hs_first";   end
      752:   begin e = mk(0, 1, 0,   0, 0, 0, 0); nm = "hs_last";    end
      753:   begin e = mk(1, 1, 0,   0, 0, 0, 0); nm = "hs_off";     end
      801:   begin e = mk(1, 1, 1,   0, 1, 1, 0); nm = "line1";      end
      6401:  begin e = mk(1, 1, 0,   0, 0, 1, 0); nm = "v_blank";    end
      8001:  begin e = mk(1, 0, 0,   0, 0, 1, 0); nm = "vs_first";   end
      9600:  begin e = mk(1, 0, 0,   0, 0, 0, 0); nm = "vs_last";    end
      9601:  begin e = mk(1, 1, 0,   0, 0, 1, 0); nm = "vs_off";     end
      12000: begin e = mk(1, 1, 0,   0, 0, 0, 0); nm = "frame_end";  end
      12001: begin e = mk(1, 1, 1,   0, 0, 1, 1); nm = "wrap";       end
      12901: begin e = mk(1, 1, 1, 100, 1, 0, 0); nm = "stall_x";    end
      12902: begin e = mk(1, 1, 1, 101, 1, 0, 0); nm = "resume";     end
      24001: begin e = mk(1, 1, 1,   0, 0, 1, 1); nm = "wrap_stall"; end
      28301: begin e = mk(1, 1, 1, 300, 5, 0, 0); nm = "pre_reset";  end
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  task automatic cyc(input logic rst, input logic en);
    obs_t  e;
    string nm;
    @(negedge clk_in);
    reset  = rst;
    enable = en;
    if (!rst) begin
      n   = 0;
      cur = mk(1, 1, 0, 0, 0, 0, 0);
      nm  = "reset";
    end else if (en) begin
      n++;
      if (directed(n, e, nm)) cur = e;
      else begin
        cur = model(n);
        nm  = "raster";
      end
    end else begin
      nm = "stall_hold";
    end
    exp_q.push_back(cur);
    name_q.push_back(nm);
  endtask

  initial begin
    obs_t  got, e;
    string nm;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = mk(hsync, vsync, video_on, int'(x), int'(y), line_start, frame_start);
        checks++;
        if (got !== e) begin
          fails++;
          $display("FAIL %s t=%0t: got hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b, expected hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b",
                   nm, $time, got.hs, got.vs, got.von, got.x, got.y, got.ls, got.fs,
                   e.hs, e.vs, e.von, e.x, e.y, e.ls, e.fs);
        end
      end
    end
  end

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    cur    = mk(1, 1, 0, 0, 0, 0, 0);
    repeat (2) cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1);
    while (n < 12901) cyc(1'b1, 1'b1);
    repeat (10) cyc(1'b1, 1'b0);
    while (n < 28301) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    repeat (900) cyc(1'b1, 1'b1);
    repeat (3) @(negedge clk_in);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no completion by %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
